btb_2way: RTL and testbench

BTB_2WAY -- requirements
Module: btb_2way

---
 rtl/btb_2way.sv | 144 ++++++++++++++
 tb/tb_btb_2way.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_2way.sv
// btb_2way: 2-way set-associative branch target buffer; combinational lookup, updates at posedge, no backpressure.
// Define BTB_CTR_HYST_EN to gate predictions on counter[1] and decrement instead of invalidate on not-taken.
module btb_2way #(
   parameter int SETS  = 512,
   parameter int TAG_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lookup_pc,
   output logic        btb_hit,
   output logic [31:0] btb_pc,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   input  logic        flush
);
   localparam int IDX_W = $clog2(SETS);
   localparam int HI    = IDX_W + TAG_W + 2;

   logic [IDX_W-1:0] l_idx, u_idx;
   logic [TAG_W-1:0] l_tag, u_tag;
   assign l_idx = lookup_pc[IDX_W+1:2];
   assign u_idx = upd_pc[IDX_W+1:2];
   assign l_tag = lookup_pc[HI-1:IDX_W+2];
   assign u_tag = upd_pc[HI-1:IDX_W+2];

   logic unused_lo;
   assign unused_lo = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};
   generate
      if (HI < 32) begin : g_unused_hi
         logic unused_hi;
         assign unused_hi = ^{lookup_pc[31:HI], upd_pc[31:HI]};
      end
   endgenerate

   logic [SETS-1:0]      v0_q, v0_d, v1_q, v1_d, lru_q, lru_d;
   logic [SETS-1:0][1:0] ctr0_q, ctr0_d, ctr1_q, ctr1_d;
   logic [TAG_W-1:0]     tag0_q [SETS];
   logic [TAG_W-1:0]     tag1_q [SETS];
   logic [29:0]          tgt0_q [SETS];
   logic [29:0]          tgt1_q [SETS];

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'd3) ? c : c + 2'd1;
   endfunction

   // Lookup: way0 wins when both ways match.
   logic        l_m0, l_m1, l_qual;
   logic [29:0] l_tgt;
   always_comb begin
      l_m0  = v0_q[l_idx] && (tag0_q[l_idx] == l_tag);
      l_m1  = v1_q[l_idx] && (tag1_q[l_idx] == l_tag);
      l_tgt = l_m0 ? tgt0_q[l_idx] : tgt1_q[l_idx];
`ifdef BTB_CTR_HYST_EN
      l_qual = l_m0 ? ctr0_q[l_idx][1] : ctr1_q[l_idx][1];
`else
      l_qual = 1'b1;
`endif
      btb_hit = (l_m0 || l_m1) && l_qual;
      btb_pc  = btb_hit ? {l_tgt, 2'b00} : 32'd0;
   end

   logic u_m0, u_m1, hit_way, victim, wr0, wr1, wr_tag;
   always_comb begin
      v0_d   = v0_q;
      v1_d   = v1_q;
      lru_d  = lru_q;
      ctr0_d = ctr0_q;
      ctr1_d = ctr1_q;
      wr0    = 1'b0;
      wr1    = 1'b0;
      wr_tag = 1'b0;
      u_m0    = v0_q[u_idx] && (tag0_q[u_idx] == u_tag);
      u_m1    = v1_q[u_idx] && (tag1_q[u_idx] == u_tag);
      hit_way = !u_m0;
      victim  = !v0_q[u_idx] ? 1'b0 : (!v1_q[u_idx] ? 1'b1 : lru_q[u_idx]);
      if (flush) begin
         v0_d  = '0;
         v1_d  = '0;
         lru_d = '0;
      end else if (upd_valid) begin
         if (u_m0 || u_m1) begin
            if (upd_taken) begin
               if (hit_way) begin
                  wr1 = 1'b1;
                  ctr1_d[u_idx] = sat_inc(ctr1_q[u_idx]);
               end else begin
                  wr0 = 1'b1;
                  ctr0_d[u_idx] = sat_inc(ctr0_q[u_idx]);
               end
               lru_d[u_idx] = ~hit_way;
            end else begin
`ifdef BTB_CTR_HYST_EN
               if (hit_way) begin
                  if (ctr1_q[u_idx] != 2'd0) ctr1_d[u_idx] = ctr1_q[u_idx] - 2'd1;
               end else begin
                  if (ctr0_q[u_idx] != 2'd0) ctr0_d[u_idx] = ctr0_q[u_idx] - 2'd1;
               end
`else
               if (hit_way) v1_d[u_idx] = 1'b0;
               else         v0_d[u_idx] = 1'b0;
`endif
            end
         end else if (upd_taken) begin
            wr_tag = 1'b1;
            if (victim) begin
               wr1 = 1'b1;
               v1_d[u_idx]   = 1'b1;
               ctr1_d[u_idx] = 2'b10;
            end else begin
               wr0 = 1'b1;
               v0_d[u_idx]   = 1'b1;
               ctr0_d[u_idx] = 2'b10;
            end
            lru_d[u_idx] = ~victim;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v0_q   <= '0;
         v1_q   <= '0;
         lru_q  <= '0;
         ctr0_q <= '0;
         ctr1_q <= '0;
      end else begin
         v0_q   <= v0_d;
         v1_q   <= v1_d;
         lru_q  <= lru_d;
         ctr0_q <= ctr0_d;
         ctr1_q <= ctr1_d;
      end
   end

   // Tag and target storage is never reset; valid bits qualify it.
   always_ff @(posedge clk) begin
      if (wr0) tgt0_q[u_idx] <= upd_target[31:2];
      if (wr1) tgt1_q[u_idx] <= upd_target[31:2];
      if (wr0 && wr_tag) tag0_q[u_idx] <= u_tag;
      if (wr1 && wr_tag) tag1_q[u_idx] <= u_tag;
   end
endmodule

// File: tb/tb_btb_2way.sv
// Randomized bench for btb_2way with an entry-level reference model and literal scenario checks.
module tb_btb_2way;
   localparam int SETS = 16;
   localparam int TAG_W = 8;
   localparam int IDX_W = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] lookup_pc = '0;
   logic        btb_hit;
   logic [31:0] btb_pc;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic [31:0] upd_target = '0;
   logic        upd_taken = 1'b0;
   logic        flush = 1'b0;

   btb_2way #(.SETS(SETS), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .btb_hit(btb_hit), .btb_pc(btb_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .flush(flush)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit cmp_on = 1'b0;

   // Reference state: one record per (set, way) plus a victim pointer per set.
   bit        mv   [SETS][2];
   int        mtag [SETS][2];
   bit [31:0] mtgt [SETS][2];
   int        mctr [SETS][2];
   int        mlru [SETS];

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic int set_of(logic [31:0] pc);
      return int'((pc >> 2) % SETS);
   endfunction

   function automatic int tag_of(logic [31:0] pc);
      return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
   endfunction

   function automatic int find_way(logic [31:0] pc);
      int s = set_of(pc);
      for (int w = 0; w < 2; w++)
         if (mv[s][w] && mtag[s][w] == tag_of(pc)) return w;
      return -1;
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++) begin
         mlru[s] = 0;
         for (int w = 0; w < 2; w++) begin
            mv[s][w] = 1'b0;
            mctr[s][w] = 0;
         end
      end
   endfunction

   function automatic void predict(logic [31:0] pc, output logic [31:0] eh, output logic [31:0] ep);
      int w = find_way(pc);
      bit ok = (w >= 0);
`ifdef BTB_CTR_HYST_EN
      if (ok) ok = (mctr[set_of(pc)][w] >= 2);
`endif
      eh = ok ? 32'd1 : 32'd0;
      ep = ok ? mtgt[set_of(pc)][w] : 32'd0;
   endfunction

   function automatic void model_apply();
      int s, w, vw;
      if (!rst) return;
      if (flush) begin
         for (int i = 0; i < SETS; i++) begin
            mlru[i] = 0;
            mv[i][0] = 1'b0;
            mv[i][1] = 1'b0;
         end
         return;
      end
      if (!upd_valid) return;
      s = set_of(upd_pc);
      w = find_way(upd_pc);
      if (w >= 0) begin
         if (upd_taken) begin
            mtgt[s][w] = upd_target & 32'hFFFF_FFFC;
            mctr[s][w] = (mctr[s][w] < 3) ? mctr[s][w] + 1 : 3;
            mlru[s] = 1 - w;
         end else begin
`ifdef BTB_CTR_HYST_EN
            mctr[s][w] = (mctr[s][w] > 0) ? mctr[s][w] - 1 : 0;
`else
            mv[s][w] = 1'b0;
`endif
         end
      end else if (upd_taken) begin
         vw = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : mlru[s]);
         mv[s][vw] = 1'b1;
         mtag[s][vw] = tag_of(upd_pc);
         mtgt[s][vw] = upd_target & 32'hFFFF_FFFC;
         mctr[s][vw] = 2;
         mlru[s] = 1 - vw;
      end
   endfunction

   always @(negedge clk) begin
      logic [31:0] eh, ep;
      if (cmp_on) begin
         predict(lookup_pc, eh, ep);
         check("cyc_hit", {31'd0, btb_hit}, eh);
         check("cyc_pc", btb_pc, ep);
      end
   end

   // One clock cycle of stimulus; optional literal expectation checked at mid-cycle.
   task automatic cyc(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                      input logic [31:0] utg, input bit utk, input bit fl,
                      input bit lit = 1'b0, input bit xh = 1'b0,
                      input logic [31:0] xp = 32'd0, input string nm = "");
      logic [31:0] mh, mp;
      lookup_pc = lpc;
      upd_valid = uv;
      upd_pc = upc;
      upd_target = utg;
      upd_taken = utk;
      flush = fl;
      if (lit) begin
         @(negedge clk);
         check({nm, "_hit"}, {31'd0, btb_hit}, {31'd0, xh});
         check({nm, "_pc"}, btb_pc, xp);
         predict(lpc, mh, mp);
         check({nm, "_model_hit"}, mh, {31'd0, xh});
         check({nm, "_model_pc"}, mp, xp);
      end
      @(posedge clk);
      model_apply();
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input bit tk);
      cyc(32'h0, 1'b1, pc, tg, tk, 1'b0);
   endtask

   task automatic probe(input string nm, input logic [31:0] pc, input bit xh, input logic [31:0] xp);
      cyc(pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, xh, xp, nm);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   function automatic logic [31:0] rpc();
      logic [31:0] p;
      p = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 3)) << 6)
        | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      return p;
   endfunction

   initial begin
      logic [31:0] up;
      model_reset();
      @(posedge clk);
      #1;
      cmp_on = 1'b1;
      probe("reset_state", 32'h100, 1'b0, 32'h0);
      rst = 1'b1;

      // Basic allocate and lookup
      upd(32'h100, 32'h2000, 1'b1);
      probe("s1_hit", 32'h100, 1'b1, 32'h2000);
      probe("s1_neighbour", 32'h104, 1'b0, 32'h0);

      // LRU eviction within one set
      do_reset();
      upd(32'h100, 32'h4000, 1'b1);
      upd(32'h100 + 4 * SETS, 32'h5000, 1'b1);
      upd(32'h100 + 8 * SETS, 32'h6000, 1'b1);
      probe("s2_evicted", 32'h100, 1'b0, 32'h0);
      probe("s2_second", 32'h100 + 4 * SETS, 1'b1, 32'h5000);
      probe("s2_third", 32'h100 + 8 * SETS, 1'b1, 32'h6000);

      // Not-taken then taken on a trained entry
      do_reset();
      upd(32'h200, 32'h7000, 1'b1);
      upd(32'h200, 32'h7000, 1'b0);
      probe("s3_after_nt", 32'h200, 1'b0, 32'h0);
      upd(32'h200, 32'h7000, 1'b1);
      probe("s3_after_t", 32'h200, 1'b1, 32'h7000);

      // Same-cycle update is not visible to the lookup
      cyc(32'h200, 1'b1, 32'h200, 32'h3000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h7000, "s4_old");
      probe("s4_new", 32'h200, 1'b1, 32'h3000);

      // Flush beats a simultaneous update
      cyc(32'h0, 1'b1, 32'h300, 32'h8000, 1'b1, 1'b1);
      probe("s5_upd_pc", 32'h300, 1'b0, 32'h0);
      probe("s5_old", 32'h200, 1'b0, 32'h0);

      // Asynchronous reset mid-cycle
      upd(32'h100, 32'h2000, 1'b1);
      probe("s6_before", 32'h100, 1'b1, 32'h2000);
      lookup_pc = 32'h100;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("s6_async_hit", {31'd0, btb_hit}, 32'd0);
      check("s6_async_pc", btb_pc, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      probe("s6_after", 32'h100, 1'b0, 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if (!rst) rst = 1'b1;
         else if ($urandom_range(0, 299) == 0) begin
            rst = 1'b0;
            model_reset();
         end
         up = rpc();
         cyc(($urandom_range(0, 2) == 0) ? up : rpc(), $urandom_range(0, 1) == 1, up,
             $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 63) == 0);
      end

      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
